// File: rtl/upc_scan_tx.sv
// upc_scan_tx: framed serial transmitter for a 3-bit UPC plus marked bit; optional even parity under UPC_TX_PARITY_EN
module upc_scan_tx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] upc,
  input  logic       marked,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [7:0] sent_count
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4;
`ifdef UPC_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [3:0] sr;
  logic [1:0] idx;
  logic tick;
  assign tick = cnt == LAST;
  assign ready = state == IDLE;
  assign busy = ~ready;
  // shift register rotates rather than shifts, so its XOR still equals the parity after DATA
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx <= 1'b1;
      done <= 1'b0;
      sent_count <= '0;
      cnt <= '0;
      sr <= '0;
      idx <= '0;
    end else begin
      done <= 1'b0;
      cnt <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
      case (state)
        IDLE: if (start) begin
          state <= START;
          tx <= 1'b0;
          sr <= {upc, marked};
          idx <= '0;
        end
        START: if (tick) begin
          state <= DATA;
          tx <= sr[3];
        end
        DATA: if (tick) begin
          if (idx == 2'd3) begin
`ifdef UPC_TX_PARITY_EN
            state <= PARITY;
            tx <= ^sr;
`else
            state <= STOP;
            tx <= 1'b1;
`endif
          end else begin
            idx <= idx + 2'd1;
            sr <= {sr[2:0], sr[3]};
            tx <= sr[2];
          end
        end
`ifdef UPC_TX_PARITY_EN
        PARITY: if (tick) begin
          state <= STOP;
          tx <= 1'b1;
        end
`endif
        STOP: if (tick) begin
          state <= IDLE;
          done <= 1'b1;
          sent_count <= sent_count + 8'd1;
        end
        default: begin
          state <= IDLE;
          tx <= 1'b1;
        end
      endcase
    end
  end
endmodule
